// File: rtl/histogram_pkg.sv
// ============================================================================
// Package  : histogram_pkg
// Purpose  : Shared sizing constants and readout FSM state type for the
//            histogram readout path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package histogram_pkg;

    localparam int HIST_BIN_COUNT     = 1024;
    localparam int HIST_ADDR_WIDTH    = 10;
    localparam int HIST_DATA_WIDTH    = 16;
    localparam int HIST_SUM_WIDTH     = 26;
    localparam int HIST_SETTLE_CYCLES = 4;

    // Readout sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_ADDR = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_SEND     = 3'd4,
        ST_FINISH   = 3'd5
    } readout_state_e;

endpackage : histogram_pkg

`default_nettype wire

// File: rtl/histogram_stats_accumulator.sv
// ============================================================================
// Module   : histogram_stats_accumulator
// Purpose  : Running sweep statistics: total of captured counts plus the
//            largest count and the address where it first appeared.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module histogram_stats_accumulator
    import histogram_pkg::*;
#(
    parameter int ADDR_WIDTH = HIST_ADDR_WIDTH,
    parameter int DATA_WIDTH = HIST_DATA_WIDTH,
    parameter int SUM_WIDTH  = HIST_SUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  accumulate_i,
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    output logic [SUM_WIDTH-1:0]  totalCount_o,
    output logic [DATA_WIDTH-1:0] peakValue_o,
    output logic [ADDR_WIDTH-1:0] peakAddress_o
);

    logic [SUM_WIDTH-1:0]  total_q, total_d;
    logic [DATA_WIDTH-1:0] peak_val_q, peak_val_d;
    logic [ADDR_WIDTH-1:0] peak_addr_q, peak_addr_d;

    // Next-state statistics; strict compare keeps the lowest address on ties
    always_comb begin
        total_d     = total_q;
        peak_val_d  = peak_val_q;
        peak_addr_d = peak_addr_q;
        if (clear_i) begin
            total_d     = '0;
            peak_val_d  = '0;
            peak_addr_d = '0;
        end else if (accumulate_i) begin
            total_d = total_q + SUM_WIDTH'(value_i);
            if (value_i > peak_val_q) begin
                peak_val_d  = value_i;
                peak_addr_d = address_i;
            end
        end
    end

    // Statistics registers, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            total_q     <= '0;
            peak_val_q  <= '0;
            peak_addr_q <= '0;
        end else begin
            total_q     <= total_d;
            peak_val_q  <= peak_val_d;
            peak_addr_q <= peak_addr_d;
        end
    end

    assign totalCount_o  = total_q;
    assign peakValue_o   = peak_val_q;
    assign peakAddress_o = peak_addr_q;

endmodule : histogram_stats_accumulator

`default_nettype wire

// File: rtl/histogram_readout_sequencer.sv
// ============================================================================
// Module   : histogram_readout_sequencer
// Purpose  : Sweeps every histogram bin through the address/value register
//            interface, streams each count on a valid/ready bin stream and
//            keeps sweep statistics (total, peak value, peak address).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module histogram_readout_sequencer
    import histogram_pkg::*;
#(
    parameter int BIN_COUNT     = HIST_BIN_COUNT,
    parameter int ADDR_WIDTH    = HIST_ADDR_WIDTH,
    parameter int DATA_WIDTH    = HIST_DATA_WIDTH,
    parameter int SETTLE_CYCLES = HIST_SETTLE_CYCLES,
    parameter int SUM_WIDTH     = HIST_SUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  histogramReadAddress_Write,
    output logic [ADDR_WIDTH-1:0] histogramReadAddress_WriteValue,
    input  logic [DATA_WIDTH-1:0] histogramReadValue__OUTPUT,
    output logic                  binValid,
    input  logic                  binReady,
    output logic [DATA_WIDTH-1:0] binData,
    output logic [ADDR_WIDTH-1:0] binAddress,
    output logic                  binLast,
    output logic [SUM_WIDTH-1:0]  totalCount,
    output logic [DATA_WIDTH-1:0] peakValue,
    output logic [ADDR_WIDTH-1:0] peakAddress
);

    localparam int                CNT_WIDTH   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0]  SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(BIN_COUNT - 1);

    readout_state_e        state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  settle_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  strobe_q;
    logic [ADDR_WIDTH-1:0] write_value_q;
    logic                  bin_valid_q;
    logic [DATA_WIDTH-1:0] bin_data_q;
    logic [ADDR_WIDTH-1:0] bin_addr_q;
    logic                  bin_last_q;

    logic                  w_abort_hit;
    logic                  w_start_accept;
    logic                  w_capture;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    // Abort only matters mid-sweep; in IDLE it also blocks a same-cycle start
    assign w_abort_hit    = abort && (state_q != ST_IDLE);
    assign w_start_accept = (state_q == ST_IDLE) && start && !abort;
    assign w_capture      = (state_q == ST_CAPTURE) && !abort;
    assign w_addr_next    = addr_q + 1'b1;

    // Sweep sequencer with registered strobe, stream and status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            settle_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            strobe_q      <= 1'b0;
            write_value_q <= '0;
            bin_valid_q   <= 1'b0;
            bin_data_q    <= '0;
            bin_addr_q    <= '0;
            bin_last_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            if (w_abort_hit) begin
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
                bin_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_start_accept) begin
                            addr_q        <= '0;
                            write_value_q <= '0;
                            strobe_q      <= 1'b1;
                            busy_q        <= 1'b1;
                            state_q       <= ST_SET_ADDR;
                        end
                    end
                    ST_SET_ADDR: begin
                        settle_q <= SETTLE_LOAD;
                        state_q  <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_q == '0) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            settle_q <= settle_q - 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        bin_data_q  <= histogramReadValue__OUTPUT;
                        bin_addr_q  <= addr_q;
                        bin_last_q  <= (addr_q == LAST_ADDR);
                        bin_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (binReady) begin
                            bin_valid_q <= 1'b0;
                            if (bin_last_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_FINISH;
                            end else begin
                                // Strobe is raised together with entry to SET_ADDR
                                addr_q        <= w_addr_next;
                                write_value_q <= w_addr_next;
                                strobe_q      <= 1'b1;
                                state_q       <= ST_SET_ADDR;
                            end
                        end
                    end
                    ST_FINISH: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    histogram_stats_accumulator #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_WIDTH  (SUM_WIDTH)
    ) u_stats (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (w_start_accept),
        .accumulate_i  (w_capture),
        .value_i       (histogramReadValue__OUTPUT),
        .address_i     (addr_q),
        .totalCount_o  (totalCount),
        .peakValue_o   (peakValue),
        .peakAddress_o (peakAddress)
    );

    assign busy                            = busy_q;
    assign done                            = done_q;
    assign histogramReadAddress_Write      = strobe_q;
    assign histogramReadAddress_WriteValue = write_value_q;
    assign binValid                        = bin_valid_q;
    assign binData                         = bin_data_q;
    assign binAddress                      = bin_addr_q;
    assign binLast                         = bin_last_q;

endmodule : histogram_readout_sequencer

`default_nettype wire
